// File: rtl/cmsdk_ahb_cmd_master.sv
// Command-driven AHB-Lite initiator: one NONSEQ transfer per valid/ready command,
// with read data, status and wait-state count returned on a valid/ready response port.
module cmsdk_ahb_cmd_master #(
  parameter int unsigned WAITW = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [1:0]       cmd_size,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic [WAITW-1:0] rsp_waits,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  output logic [3:0]       HPROT,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  input  logic             HRESP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [31:0]      r_haddr;
  logic [1:0]       r_hsize;
  logic             r_hwrite;
  logic [31:0]      r_wdata;
  logic [31:0]      r_hwdata;
  logic [31:0]      r_rdata;
  logic [1:0]       r_err;
  logic [WAITW-1:0] r_waits;

  logic             w_accept;
  logic             w_illegal;
  logic             w_addr_done;
  logic             w_data_done;
  logic             w_rsp_done;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_addr_done = (r_state == S_ADDR) && HREADY;
  assign w_data_done = (r_state == S_DATA) && HREADY;
  assign w_rsp_done  = (r_state == S_RESP) && rsp_ready;

  // Illegal sizes and misaligned accesses are answered locally, never reaching the bus.
  assign w_illegal = (cmd_size == 2'b11) ||
                     ((cmd_size == 2'b01) && cmd_addr[0]) ||
                     ((cmd_size == 2'b10) && (cmd_addr[1:0] != 2'b00));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_illegal ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_addr_done) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_data_done) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_done) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr  <= '0;
      r_hsize  <= '0;
      r_hwrite <= 1'b0;
      r_wdata  <= '0;
      r_hwdata <= '0;
      r_rdata  <= '0;
      r_err    <= '0;
      r_waits  <= '0;
    end else begin
      if (w_accept) begin
        r_wdata <= cmd_wdata;
        r_rdata <= '0;
        r_waits <= '0;
        if (w_illegal) begin
          r_err <= 2'b10;
        end else begin
          r_err    <= 2'b00;
          r_haddr  <= cmd_addr;
          r_hsize  <= cmd_size;
          r_hwrite <= cmd_write;
        end
      end

      // Write data is presented for the data phase and then held until the next write.
      if (w_addr_done && r_hwrite) begin
        r_hwdata <= r_wdata;
      end

      if (r_state == S_DATA) begin
        if (!HREADY) begin
          if (r_waits != '1) begin
            r_waits <= r_waits + 1'b1;
          end
        end else begin
          if (!r_hwrite) begin
            r_rdata <= HRDATA;
          end
          r_err <= HRESP ? 2'b01 : 2'b00;
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign rsp_waits = r_waits;

  assign HTRANS = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR  = r_haddr;
  assign HSIZE  = {1'b0, r_hsize};
  assign HWRITE = r_hwrite;
  assign HWDATA = r_hwdata;
  assign HPROT  = 4'b0011;

endmodule

// File: tb/tb_cmsdk_ahb_cmd_master.sv
// Directed bench for cmsdk_ahb_cmd_master with a small SRAM-like AHB responder
// that can insert wait states, a two-cycle ERROR, or hold HREADY low.
module tb_cmsdk_ahb_cmd_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [7:0]  rsp_waits;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [3:0]  HPROT;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  int vectors;
  int miscompares;

  cmsdk_ahb_cmd_master #(.WAITW(8)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_waits (rsp_waits),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HPROT     (HPROT),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Responder: addresses 0x5xxx_xxxx answer with a two-cycle ERROR, others are SRAM.
  logic [31:0] mem [0:15];
  logic        dph;
  logic [31:0] dph_addr;
  logic        dph_write;
  logic        dph_err;
  int          dph_left;
  int          wait_cfg;
  logic        hold_low;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph       <= 1'b0;
      dph_addr  <= '0;
      dph_write <= 1'b0;
      dph_err   <= 1'b0;
      dph_left  <= 0;
    end else begin
      if (dph) begin
        if (HREADY) begin
          if (dph_write && !dph_err) mem[dph_addr[5:2]] <= HWDATA;
          dph <= 1'b0;
        end else begin
          dph_left <= dph_left - 1;
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        dph       <= 1'b1;
        dph_addr  <= HADDR;
        dph_write <= HWRITE;
        dph_err   <= (HADDR[31:28] == 4'h5);
        dph_left  <= (HADDR[31:28] == 4'h5) ? 1 : wait_cfg;
      end
    end
  end

  assign HREADY = hold_low ? 1'b0 : (dph ? (dph_left == 0) : 1'b1);
  assign HRESP  = dph && dph_err;
  assign HRDATA = (dph && !dph_write) ? mem[dph_addr[5:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command from a negedge; return cycles to rsp_valid and NONSEQ count.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] d, output int lat, output int nseq);
    chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    lat  = 1;
    nseq = 0;
    while (!rsp_valid && lat < 40) begin
      if (HTRANS == 2'b10) nseq++;
      @(negedge HCLK);
      lat++;
    end
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  int lat;
  int nseq;
  logic [31:0] hold_rdata;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    wait_cfg  = 0;
    hold_low  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    HRESETn   = 1'b0;
    repeat (2) @(negedge HCLK);

    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_waits", 32'(rsp_waits), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("hprot", 32'(HPROT), 32'h3);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Zero-wait word write then read back
    run_cmd(1'b1, 32'h2000_0010, 2'b10, 32'hDEAD_BEEF, lat, nseq);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_nonseq", 32'(nseq), 32'd1);
    chk("wr_err", 32'(rsp_err), 32'd0);
    chk("wr_waits", 32'(rsp_waits), 32'd0);
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_haddr", HADDR, 32'h2000_0010);
    chk("wr_hsize", 32'(HSIZE), 32'd2);
    chk("wr_hwrite", 32'(HWRITE), 32'd1);
    chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    handshake();

    run_cmd(1'b0, 32'h2000_0010, 2'b10, 32'h0, lat, nseq);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_nonseq", 32'(nseq), 32'd1);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", 32'(rsp_err), 32'd0);
    chk("rd_waits", 32'(rsp_waits), 32'd0);
    chk("rd_hwrite", 32'(HWRITE), 32'd0);
    handshake();

    // Read with three data-phase wait states
    wait_cfg = 3;
    run_cmd(1'b0, 32'h2000_0010, 2'b10, 32'h0, lat, nseq);
    chk("wait_latency", 32'(lat), 32'd6);
    chk("wait_nonseq", 32'(nseq), 32'd1);
    chk("wait_waits", 32'(rsp_waits), 32'd3);
    chk("wait_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("wait_htrans_resp", 32'(HTRANS), 32'd0);
    handshake();
    wait_cfg = 0;

    // Two-cycle ERROR on an unmapped write
    run_cmd(1'b1, 32'h5000_0000, 2'b10, 32'h1234_5678, lat, nseq);
    chk("err_latency", 32'(lat), 32'd4);
    chk("err_nonseq", 32'(nseq), 32'd1);
    chk("err_status", 32'(rsp_err), 32'd1);
    chk("err_waits", 32'(rsp_waits), 32'd1);
    handshake();
    run_cmd(1'b0, 32'h2000_0010, 2'b10, 32'h0, lat, nseq);
    chk("post_err_latency", 32'(lat), 32'd3);
    chk("post_err_status", 32'(rsp_err), 32'd0);
    chk("post_err_rdata", rsp_rdata, 32'hDEAD_BEEF);
    handshake();

    // Rejected commands
    run_cmd(1'b0, 32'h2000_0001, 2'b01, 32'h0, lat, nseq);
    chk("rej_h_latency", 32'(lat), 32'd1);
    chk("rej_h_nonseq", 32'(nseq), 32'd0);
    chk("rej_h_err", 32'(rsp_err), 32'd2);
    chk("rej_h_rdata", rsp_rdata, 32'h0);
    chk("rej_h_htrans", 32'(HTRANS), 32'd0);
    chk("rej_h_haddr_held", HADDR, 32'h2000_0010);
    handshake();
    run_cmd(1'b0, 32'h2000_0002, 2'b10, 32'h0, lat, nseq);
    chk("rej_w_latency", 32'(lat), 32'd1);
    chk("rej_w_err", 32'(rsp_err), 32'd2);
    chk("rej_w_rdata", rsp_rdata, 32'h0);
    handshake();
    run_cmd(1'b1, 32'h2000_0010, 2'b11, 32'hFFFF_FFFF, lat, nseq);
    chk("rej_s_latency", 32'(lat), 32'd1);
    chk("rej_s_err", 32'(rsp_err), 32'd2);
    chk("rej_s_htrans", 32'(HTRANS), 32'd0);
    handshake();

    // Response back-pressure: five cycles with rsp_ready low
    run_cmd(1'b0, 32'h2000_0010, 2'b10, 32'h0, lat, nseq);
    hold_rdata = rsp_rdata;
    chk("bp_rdata", hold_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rdata_stable", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_err_stable", 32'(rsp_err), 32'd0);
    end
    handshake();

    // Reset pulse during an address phase stalled by HREADY=0
    hold_low  = 1'b1;
    chk("rs_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_write = 1'b0;
    cmd_addr  = 32'h2000_0010;
    cmd_size  = 2'b10;
    cmd_valid = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    chk("rs_addr_nonseq", 32'(HTRANS), 32'd2);
    @(negedge HCLK);
    chk("rs_addr_held", 32'(HTRANS), 32'd2);
    chk("rs_haddr_held", HADDR, 32'h2000_0010);
    #2 HRESETn = 1'b0;
    #1;
    chk("rs_htrans_async", 32'(HTRANS), 32'd0);
    chk("rs_cmd_ready_async", 32'(cmd_ready), 32'd1);
    chk("rs_haddr_async", HADDR, 32'h0);
    hold_low = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    run_cmd(1'b0, 32'h2000_0010, 2'b10, 32'h0, lat, nseq);
    chk("rs_after_latency", 32'(lat), 32'd3);
    chk("rs_after_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rs_after_err", 32'(rsp_err), 32'd0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
